// File: rtl/fp_pkg.sv
// Shared constants, state encoding and operand packing for the single-precision FP units.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int QW     = FRAC_W + 2;
  localparam int EXPS_W = EXP_W + 2;
  localparam int CNT_W  = 5;

  localparam logic signed [EXPS_W-1:0] BIAS    = 10'sd127;
  localparam logic signed [EXPS_W-1:0] EXP_OVF = 10'sd255;
  localparam logic [EXP_W-1:0]         EXP_MAX = 8'hFF;
  localparam logic [31:0]              QNAN    = 32'h7FC00000;
  localparam logic [CNT_W-1:0]         CNT_LAST = 5'(QW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic [31:0] inf_of(input logic sign);
    return {sign, EXP_MAX, 23'd0};
  endfunction
endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
module fp_div_mant_iter
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W-1:0] m1,
  input  logic [MANT_W-1:0] m2,
  output logic [QW-1:0]     q
);
  logic [QW-1:0]     rem;
  logic [QW-1:0]     rem_sel;
  logic [MANT_W-1:0] div;
  logic              ge;

  // Remainder always stays below twice the divisor, so the shifted value fits QW bits.
  always_comb begin
    ge      = (rem >= {1'b0, div});
    rem_sel = ge ? (rem - {1'b0, div}) : rem;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem <= {QW{1'b0}};
      div <= {MANT_W{1'b0}};
      q   <= {QW{1'b0}};
    end else if (load) begin
      rem <= {1'b0, m1};
      div <= m2;
      q   <= {QW{1'b0}};
    end else if (step) begin
      rem <= rem_sel << 1;
      q   <= {q[QW-2:0], ge};
    end else begin
      rem <= rem;
      div <= div;
      q   <= q;
    end
  end
endmodule

// File: rtl/fp_div.sv
// IEEE-754 single-precision divider with valid/ready handshakes, one operation in flight.
module fp_div
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] S,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t state, state_nxt;
  fp32_t  a, b;
  logic   accept;
  logic   special;
  logic   sign_in;
  logic [31:0] special_res;
  logic signed [EXPS_W-1:0] exp_in;

  logic                     sign_r;
  logic signed [EXPS_W-1:0] exp_r;
  logic [CNT_W-1:0]         cnt;
  logic [QW-1:0]            q;

  logic signed [EXPS_W-1:0] e_norm;
  logic [FRAC_W-1:0]        frac_norm;
  logic [31:0]              norm_res;

  assign a      = num1;
  assign b      = num2;
  assign accept = in_valid & in_ready;

  // Operand classification; exponent field 0 means zero, FF (inf or NaN) yields qNaN.
  always_comb begin
    sign_in     = a.sign ^ b.sign;
    exp_in      = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + BIAS;
    special     = 1'b1;
    special_res = QNAN;
    if (a.exp == EXP_MAX || b.exp == EXP_MAX) begin
      special_res = QNAN;
    end else if (a.exp == 8'd0 && b.exp == 8'd0) begin
      special_res = QNAN;
    end else if (b.exp == 8'd0) begin
      special_res = inf_of(sign_in);
    end else if (a.exp == 8'd0) begin
      special_res = {sign_in, 31'd0};
    end else begin
      special     = 1'b0;
      special_res = 32'd0;
    end
  end

  fp_div_mant_iter u_iter (
    .clk  (clk),
    .rstn (rstn),
    .load (accept & ~special),
    .step (state == DIVIDE),
    .m1   ({1'b1, a.frac}),
    .m2   ({1'b1, b.frac}),
    .q    (q)
  );

  // Quotient lies in (0.5,2): shift left once when below 1; truncate, saturate to inf, flush to zero.
  always_comb begin
    if (q[QW-1]) begin
      frac_norm = q[QW-2:1];
      e_norm    = exp_r;
    end else begin
      frac_norm = q[QW-3:0];
      e_norm    = exp_r - 10'sd1;
    end
    if (e_norm >= EXP_OVF) begin
      norm_res = inf_of(sign_r);
    end else if (e_norm <= 10'sd0) begin
      norm_res = {sign_r, 31'd0};
    end else begin
      norm_res = {sign_r, e_norm[EXP_W-1:0], frac_norm};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Leaving DONE needs the result to have been presented, so a special result is never skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (special ? DONE : DIVIDE) : IDLE;
      DIVIDE:  state_nxt = (cnt == 5'd0) ? NORM : DIVIDE;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = (out_valid && out_ready) ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_r    <= 1'b0;
      exp_r     <= 10'sd0;
      cnt       <= 5'd0;
      S         <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r <= sign_in;
            exp_r  <= exp_in;
            cnt    <= CNT_LAST;
            if (special) S <= special_res;
          end
        end
        DIVIDE: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        NORM: begin
          S         <= norm_res;
          out_valid <= 1'b1;
        end
        DONE: begin
          out_valid <= ~(out_valid & out_ready);
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div.sv
// Directed and random checks of fp_div against an arithmetic reference model.
module tb_fp_div;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] num1, num2;
  logic        in_valid, in_ready;
  logic [31:0] S;
  logic        out_valid, out_ready;

  int total = 0;
  int bad   = 0;

  fp_div dut (
    .clk(clk), .rstn(rstn), .num1(num1), .num2(num2),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF) || (x[30:23] == 8'h00) || (y[30:23] == 8'h00);
  endfunction

  // Quotient from integer division of the mantissas, truncated to 24 significant bits.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic sg;
    int ex, ey, e;
    longint unsigned m1, m2, qq, fr;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 255 || ey == 255) return 32'h7FC00000;
    if (ex == 0 && ey == 0) return 32'h7FC00000;
    if (ey == 0) return {sg, 8'hFF, 23'd0};
    if (ex == 0) return {sg, 31'd0};
    m1 = 64'h800000 + 64'(x[22:0]);
    m2 = 64'h800000 + 64'(y[22:0]);
    qq = (m1 << 24) / m2;
    e  = ex - ey + 127;
    if (qq >= 64'h1000000) begin
      fr = (qq >> 1) % 64'h800000;
    end else begin
      fr = qq % 64'h800000;
      e  = e - 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, e[7:0], fr[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Issue one operation and wait for out_valid; checks latency and result, leaves it in DONE.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    int edges;
    int lat;
    lat = is_special(x, y) ? 1 : 26;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    num1 = x; num2 = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_S"}, S, ref_div(x, y));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] x, y, held;
    rstn = 1'b0; num1 = 32'd0; num2 = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", S, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("six_by_two", 32'h40C00000, 32'h40000000);
    check("six_by_two_lit", S, 32'h40400000);
    release_out("six_by_two");
    run_op("one_third", 32'h3F800000, 32'h40400000);
    check("one_third_lit", S, 32'h3EAAAAAA);
    release_out("one_third");
    run_op("neg_half", 32'hBF800000, 32'h3F000000);
    check("neg_half_lit", S, 32'hC0000000);
    release_out("neg_half");
    run_op("div_zero", 32'h3F800000, 32'h00000000);
    check("div_zero_lit", S, 32'h7F800000);
    release_out("div_zero");
    run_op("overflow", 32'h7F000000, 32'h3E800000);
    release_out("overflow");
    run_op("underflow", 32'h00800000, 32'h40000000);
    release_out("underflow");
    run_op("inf_num", 32'h7F800000, 32'h3F800000);
    release_out("inf_num");
    run_op("zero_zero", 32'h80000000, 32'h00000000);
    release_out("zero_zero");
    run_op("zero_num", 32'h80000000, 32'h40A00000);
    release_out("zero_num");

    // Backpressure: result held, new operands refused.
    run_op("bp", 32'h40C00000, 32'h40000000);
    held = S;
    for (int i = 0; i < 5; i++) begin
      num1 = 32'h3F800000; num2 = 32'h40400000;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_S", S, held);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    @(posedge clk); #1;
    check("bp_no_ghost", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a division.
    num1 = 32'h40C00000; num2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_S", S, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_op("after_abort", 32'h40C00000, 32'h40000000);
    check("after_abort_lit", S, 32'h40400000);
    release_out("after_abort");

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 8 != 7) begin
        x[30:23] = 8'($urandom_range(1, 254));
        y[30:23] = 8'($urandom_range(1, 254));
      end
      run_op("rand", x, y);
      release_out("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
